// File: rtl/mac_colseq_pipe_pkg.sv
// Shared widths, zero-select helper and the column packet carried into stage 1.
package mac_colseq_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int GROUP_SIZE = 8;
  localparam int NUM_GROUPS = 2;
  localparam int COL_BITS   = 3;
  localparam int ACC_WIDTH  = 22;
  localparam int VEC_LENGTH = GROUP_SIZE * NUM_GROUPS;
  localparam int SEL_W      = $clog2(GROUP_SIZE) + 1;
  localparam int HSEL_W     = $clog2(VEC_LENGTH) + 1;
  localparam int GSUM_W     = $clog2(GROUP_SIZE) + DATA_WIDTH;

  // A select code at or beyond the lane count contributes zero instead of a lane.
  function automatic logic is_zero_code(input int code, input int limit);
    return code >= limit;
  endfunction

  typedef struct packed {
    logic [VEC_LENGTH/2-1:0][SEL_W-1:0] act_sel;
    logic [NUM_GROUPS-1:0]              skip_zero;
    logic [COL_BITS-1:0]                col_idx;
    logic                               is_msb;
    logic [HSEL_W-1:0]                  ham_sel;
    logic                               ham_sign;
    logic [2:0]                         mul_const;
    logic                               mul_shift;
    logic                               last;
  } col_pkt_t;
endpackage

// File: rtl/mac_colseq_pipe_colsum_term.sv
// Combinational stage-1 term for one column packet: lane selection, group sums,
// MSB/Hamming negation, column shift and constant-multiplier term.
module colsum_term
  import mac_colseq_pkg::*;
#(
  parameter int DATA_WIDTH = mac_colseq_pkg::DATA_WIDTH,
  parameter int GROUP_SIZE = mac_colseq_pkg::GROUP_SIZE,
  parameter int NUM_GROUPS = mac_colseq_pkg::NUM_GROUPS,
  parameter int ACC_WIDTH  = mac_colseq_pkg::ACC_WIDTH,
  localparam int VEC_LENGTH = GROUP_SIZE * NUM_GROUPS,
  localparam int GSUM_W     = $clog2(GROUP_SIZE) + DATA_WIDTH
) (
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act,
  input  logic [NUM_GROUPS-1:0][GSUM_W-1:0]     sum_act,
  input  col_pkt_t                              pkt,
  output logic signed [ACC_WIDTH-1:0]           term,
  output logic                                  last
);
  localparam int HALF   = GROUP_SIZE / 2;
  localparam int LANE_W = $clog2(VEC_LENGTH);
  localparam int SEL_W  = $clog2(GROUP_SIZE) + 1;

  logic signed [ACC_WIDTH-1:0] slot_val [VEC_LENGTH/2];
  logic signed [ACC_WIDTH-1:0] grp_sel  [NUM_GROUPS];
  logic signed [ACC_WIDTH-1:0] grp_tot  [NUM_GROUPS];

  for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_group
    logic signed [ACC_WIDTH-1:0] psum;

    // Each slot picks a lane local to its own group.
    for (genvar ki = 0; ki < HALF; ki++) begin : g_slot
      logic [SEL_W-1:0]  sel;
      logic [LANE_W-1:0] lane;
      assign sel  = pkt.act_sel[gi*HALF+ki];
      assign lane = LANE_W'(gi*GROUP_SIZE) + LANE_W'(sel);
      assign slot_val[gi*HALF+ki] = is_zero_code(int'(sel), GROUP_SIZE)
                                    ? '0 : ACC_WIDTH'($signed(act[lane]));
    end

    always_comb begin
      psum = '0;
      for (int k = 0; k < HALF; k++) psum = psum + slot_val[gi*HALF+k];
    end

    // Complement mode recovers the unselected half from the precomputed group sum.
    assign grp_tot[gi] = ACC_WIDTH'($signed(sum_act[gi]));
    assign grp_sel[gi] = pkt.skip_zero[gi] ? psum : grp_tot[gi] - psum;
  end

  logic signed [ACC_WIDTH-1:0] s1, tot, ham_act, col_term, ham_term, mul_term;

  always_comb begin
    s1  = '0;
    tot = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      s1  = s1 + grp_sel[g];
      tot = tot + grp_tot[g];
    end
  end

  assign ham_act  = is_zero_code(int'(pkt.ham_sel), VEC_LENGTH)
                    ? '0 : ACC_WIDTH'($signed(act[pkt.ham_sel[LANE_W-1:0]]));
  assign col_term = (pkt.is_msb ? -s1 : s1) <<< pkt.col_idx;
  assign ham_term = (pkt.ham_sign ? -ham_act : ham_act) <<< pkt.col_idx;
  assign mul_term = (tot * $signed(ACC_WIDTH'(pkt.mul_const))) <<< (pkt.mul_shift ? 2'd3 : 2'd0);
  assign term     = col_term + ham_term + mul_term;
  assign last     = pkt.last;
endmodule

// File: rtl/mac_colseq_pipe.sv
// Handshaked bit-column MAC: stage 1 registers the column term, stage 2 accumulates
// and emits one dot-product result per last column.
module mac_colseq_pipe
  import mac_colseq_pkg::*;
#(
  parameter int DATA_WIDTH = mac_colseq_pkg::DATA_WIDTH,
  parameter int GROUP_SIZE = mac_colseq_pkg::GROUP_SIZE,
  parameter int NUM_GROUPS = mac_colseq_pkg::NUM_GROUPS,
  parameter int COL_BITS   = mac_colseq_pkg::COL_BITS,
  parameter int ACC_WIDTH  = mac_colseq_pkg::ACC_WIDTH,
  localparam int VEC_LENGTH = GROUP_SIZE * NUM_GROUPS,
  localparam int SEL_W      = $clog2(GROUP_SIZE) + 1,
  localparam int HSEL_W     = $clog2(VEC_LENGTH) + 1,
  localparam int GSUM_W     = $clog2(GROUP_SIZE) + DATA_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  act,
  input  logic [NUM_GROUPS-1:0][GSUM_W-1:0]      sum_act,
  input  logic                                   col_valid,
  output logic                                   col_ready,
  input  logic                                   col_last,
  input  logic [VEC_LENGTH/2-1:0][SEL_W-1:0]     act_sel,
  input  logic [NUM_GROUPS-1:0]                  skip_zero,
  input  logic [COL_BITS-1:0]                    col_idx,
  input  logic                                   is_msb,
  input  logic [HSEL_W-1:0]                      ham_sel,
  input  logic                                   ham_sign,
  input  logic [2:0]                             mul_const,
  input  logic                                   mul_shift,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [ACC_WIDTH-1:0]            out_result
);
  col_pkt_t                    pkt;
  logic signed [ACC_WIDTH-1:0] term;
  logic                        term_last;
  logic                        adv;
  logic                        v1_reg, last1_reg, out_valid_reg;
  logic signed [ACC_WIDTH-1:0] term1_reg, acc_reg, out_result_reg, acc_next;

  assign pkt.act_sel   = act_sel;
  assign pkt.skip_zero = skip_zero;
  assign pkt.col_idx   = col_idx;
  assign pkt.is_msb    = is_msb;
  assign pkt.ham_sel   = ham_sel;
  assign pkt.ham_sign  = ham_sign;
  assign pkt.mul_const = mul_const;
  assign pkt.mul_shift = mul_shift;
  assign pkt.last      = col_last;

  colsum_term #(
    .DATA_WIDTH (DATA_WIDTH),
    .GROUP_SIZE (GROUP_SIZE),
    .NUM_GROUPS (NUM_GROUPS),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_term (
    .act     (act),
    .sum_act (sum_act),
    .pkt     (pkt),
    .term    (term),
    .last    (term_last)
  );

  // A stalled result freezes the whole pipe, so nothing upstream can be overwritten.
  assign adv       = !out_valid_reg || out_ready;
  assign col_ready = adv;
  assign acc_next  = acc_reg + term1_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_reg         <= 1'b0;
      last1_reg      <= 1'b0;
      term1_reg      <= '0;
      acc_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
    end else if (adv) begin
      v1_reg    <= col_valid;
      last1_reg <= term_last;
      term1_reg <= term;
      if (v1_reg && last1_reg) begin
        out_result_reg <= acc_next;
        acc_reg        <= '0;
        out_valid_reg  <= 1'b1;
      end else begin
        if (v1_reg) acc_reg <= acc_next;
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
endmodule

// File: tb/tb_mac_colseq_pipe.sv
// Scoreboard bench for mac_colseq_pipe: driver pushes reference results, monitor pops on output handshakes.
module tb_mac_colseq_pipe;
  localparam int DW = 8, GS = 8, NG = 2, VL = 16, AW = 22;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [VL-1:0][DW-1:0] act = '0;
  logic [NG-1:0][10:0]   sum_act = '0;
  logic              col_valid = 1'b0, col_ready, col_last = 1'b0;
  logic [VL/2-1:0][3:0]  act_sel = '0;
  logic [NG-1:0]     skip_zero = '0;
  logic [2:0]        col_idx = '0;
  logic              is_msb = 1'b0;
  logic [4:0]        ham_sel = 5'd16;
  logic              ham_sign = 1'b0;
  logic [2:0]        mul_const = '0;
  logic              mul_shift = 1'b0;
  logic              out_valid, out_ready = 1'b1;
  logic [AW-1:0]     out_result;

  int n_checks = 0, n_fail = 0, cyc = 0, out_count = 0, ready_mode = 1;
  longint model_acc = 0;
  logic [AW-1:0] exp_q[$];

  mac_colseq_pipe dut (
    .clk(clk), .reset(reset), .act(act), .sum_act(sum_act),
    .col_valid(col_valid), .col_ready(col_ready), .col_last(col_last),
    .act_sel(act_sel), .skip_zero(skip_zero), .col_idx(col_idx), .is_msb(is_msb),
    .ham_sel(ham_sel), .ham_sign(ham_sign), .mul_const(mul_const), .mul_shift(mul_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: the column term straight from the arithmetic definition, in wide integers.
  function automatic longint model_term();
    longint s1, tot, ah, p, sa;
    int sel;
    s1 = 0; tot = 0; ah = 0;
    for (int g = 0; g < NG; g++) begin
      p  = 0;
      sa = longint'($signed(sum_act[g]));
      for (int k = 0; k < GS/2; k++) begin
        sel = int'(act_sel[g*(GS/2)+k]);
        if (sel < GS) p += longint'($signed(act[g*GS+sel]));
      end
      tot += sa;
      s1  += skip_zero[g] ? p : sa - p;
    end
    if (ham_sel < 5'd16) ah = longint'($signed(act[ham_sel[3:0]]));
    if (is_msb) s1 = -s1;
    if (ham_sign) ah = -ah;
    return (s1 + ah) * (longint'(1) << col_idx) + tot * longint'(mul_const) * (mul_shift ? 8 : 1);
  endfunction

  // Present the current fields until accepted; on accept update the model and scoreboard.
  task automatic send_col(input bit last, input bit use_exp, input longint exp_v);
    bit ok = 0;
    int n = 0;
    col_valid = 1'b1;
    col_last  = last;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = col_ready;
      if (ok) begin
        model_acc += model_term();
        if (last) begin
          exp_q.push_back(use_exp ? exp_v[AW-1:0] : model_acc[AW-1:0]);
          model_acc = 0;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    col_valid = 1'b0;
    col_last  = 1'b0;
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic rand_fields();
    for (int i = 0; i < VL/2; i++) act_sel[i] = 4'($urandom_range(0, GS));
    skip_zero = 2'($urandom);
    col_idx   = 3'($urandom);
    is_msb    = 1'($urandom);
    ham_sel   = 5'($urandom_range(0, VL));
    ham_sign  = 1'($urandom);
    mul_const = 3'($urandom);
    mul_shift = 1'($urandom);
  endtask

  task automatic rand_data();
    for (int i = 0; i < VL; i++) act[i] = 8'($urandom);
    for (int g = 0; g < NG; g++) sum_act[g] = 11'($urandom_range(0, 2047));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // out_ready driver: 0 = hold low, 1 = hold high, 2 = random.
  initial forever begin
    @(posedge clk); #2;
    case (ready_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: pops one expected result per output handshake, checks stall stability.
  initial begin
    bit held_v = 0;
    logic [AW-1:0] held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_v = 0;
      end else begin
        chk("col_ready_rule", 32'(col_ready), 32'(!out_valid || out_ready));
        if (held_v) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_result", 32'(out_result), 32'(held));
        end
        held_v = out_valid && !out_ready;
        held   = out_result;
        if (out_valid && out_ready) begin
          out_count++;
          if (exp_q.size() == 0) chk("unexpected_result", 32'(out_result), 32'hFFFFFFFF);
          else chk("result", 32'(out_result), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int t0, o0;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_result", 32'(out_result), 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("post_reset_col_ready", 32'(col_ready), 32'd1);
    @(posedge clk); #1;

    // Test 1: all-ones activations, eight columns, MSB negated
    for (int i = 0; i < VL; i++) act[i] = 8'd1;
    sum_act = {11'd8, 11'd8};
    skip_zero = 2'b11;
    for (int i = 0; i < VL/2; i++) act_sel[i] = 4'(i % 4);
    ham_sel = 5'd16; ham_sign = 0; mul_const = 0; mul_shift = 0;
    for (int c = 0; c < 8; c++) begin
      col_idx = 3'(c);
      is_msb  = (c == 7);
      send_col(c == 7, 1, -8);
    end
    drain();

    // Test 2: complement sums, single column, latency
    for (int i = 0; i < VL; i++) act[i] = (i % 8 < 4) ? 8'(i % 8 + 1) : 8'd7;
    sum_act = {11'd40, 11'd40};
    skip_zero = 2'b00;
    col_idx = 3'd2; is_msb = 0;
    send_col(1, 1, 240);
    chk("latency_not_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("latency_valid", 32'(out_valid), 32'd1);
    drain();

    // Test 3: Hamming and constant-multiplier terms only
    act = '0;
    act[3] = 8'hFB;
    for (int i = 0; i < VL/2; i++) act_sel[i] = 4'd8;
    skip_zero = 2'b11;
    sum_act = {11'd4, 11'd2};
    col_idx = 3'd1; is_msb = 0;
    ham_sel = 5'd3; ham_sign = 1;
    mul_const = 3'd3; mul_shift = 1;
    send_col(1, 1, 154);
    drain();

    // Test 4: output stalled for 5 cycles with columns waiting
    rand_data();
    ready_mode = 0;
    fork
      begin
        for (int i = 0; i < 3; i++) begin rand_fields(); send_col(1, 0, 0); end
      end
      begin
        int n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        chk("stall_reached", 32'(out_valid), 32'd1);
        repeat (5) begin
          @(negedge clk);
          chk("stall_col_ready", 32'(col_ready), 32'd0);
        end
        ready_mode = 1;
      end
    join
    drain();

    // Test 5a: back-to-back single-column dot products
    rand_data();
    t0 = cyc; o0 = out_count;
    for (int i = 0; i < 6; i++) begin rand_fields(); send_col(1, 0, 0); end
    chk("b2b_accept_cycles", 32'(cyc - t0), 32'd6);
    repeat (3) begin @(posedge clk); #1; end
    chk("b2b_results", 32'(out_count - o0), 32'd6);
    drain();

    // Randomised dot products with random back-pressure
    ready_mode = 2;
    for (int d = 0; d < 40; d++) begin
      int len;
      rand_data();
      len = $urandom_range(1, 4);
      for (int c = 0; c < len; c++) begin rand_fields(); send_col(c == len - 1, 0, 0); end
    end
    ready_mode = 1;
    drain();

    // Test 5b: reset in the middle of a dot product
    rand_data();
    for (int i = 0; i < 3; i++) begin rand_fields(); send_col(0, 0, 0); end
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_acc = 0;
    @(negedge clk);
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_col_ready", 32'(col_ready), 32'd1);
    @(posedge clk); #1;
    rand_fields();
    send_col(1, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
